fetch_sequencer: RTL and testbench

- Sequences the 32-entry instruction memory: owns the program counter and drives the memory's output-enable/control input.
- Captures each fetched word into an instruction register and hands it to decode/execute over a valid/ready handshake.
- Two modes: free-running (run) and button-driven single-step; a halt state ends the program.
- Sits between the instruction memory and the decode/execute stage of the lab CPU.

---
 rtl/fetch_sequencer.sv | 129 ++++++++++++
 tb/tb_fetch_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, strobes the instruction memory and hands each word to decode.
// Optional build macro FETCH_HALT_ON_NOP_EN: halt after delivering a NOP_WORD instruction.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W   = 5,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       PROG_LEN = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_btn,
    input  logic              run_mode,
    output logic              mem_en,
    output logic [ADDR_W-1:0] pc_out,
    input  logic [DATA_W-1:0] instr_in,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_HALT
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

`ifdef FETCH_HALT_ON_NOP_EN
    localparam bit HALT_ON_NOP = 1'b1;
`else
    localparam bit HALT_ON_NOP = 1'b0;
`endif

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                halted_q, halted_d;
    logic                btn_prev_q;

    logic step_pulse;
    logic handshake;
    logic end_of_prog;

    assign step_pulse = step_btn & ~btn_prev_q;
    assign handshake  = valid_q & instr_ready;
    // A delivered word ends the program at the last PC, or on a NOP when that build option is on.
    assign end_of_prog = (pc_q == LAST_PC) || (HALT_ON_NOP && (instr_q == NOP_WORD));

    // NOTE: every variable gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;

        unique case (state_q)
            S_IDLE: begin
                if (run_mode || step_pulse) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                instr_d = instr_in;
                valid_d = 1'b1;
                state_d = S_HOLD;
            end

            S_HOLD: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (jump_en) begin
                        pc_d    = jump_addr;
                        state_d = run_mode ? S_FETCH : S_IDLE;
                    end else if (end_of_prog) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = run_mode ? S_FETCH : S_IDLE;
                    end
                end
            end

            S_HALT: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            // Treat the button as already pressed so one held through reset is not a step request.
            btn_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            btn_prev_q <= step_btn;
        end
    end

    assign mem_en      = (state_q == S_FETCH);
    assign pc_out      = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: per-cycle vector table, hand-written corner sequences,
// and a scoreboard of expected {pc, instruction} pairs compared on every valid/ready handshake.
module tb_fetch_sequencer;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int PROG_LEN = 32;
    localparam logic [31:0] NOP = 32'h00000013;
`ifdef FETCH_HALT_ON_NOP_EN
    localparam int RUN_LAST = 6;
`else
    localparam int RUN_LAST = PROG_LEN - 1;
`endif

    logic              clk;
    logic              rst;
    logic              step_btn;
    logic              run_mode;
    logic              mem_en;
    logic [ADDR_W-1:0] pc_out;
    logic [DATA_W-1:0] instr_in;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              instr_ready;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              halted;

    fetch_sequencer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .PROG_LEN(PROG_LEN),
        .NOP_WORD(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_btn   (step_btn),
        .run_mode   (run_mode),
        .mem_en     (mem_en),
        .pc_out     (pc_out),
        .instr_in   (instr_in),
        .instr_out  (instr_out),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data is only meaningful while mem_en is high.
    logic [31:0] mem [PROG_LEN];
    assign instr_in = mem_en ? mem[pc_out] : 32'hDEAD_BEEF;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       instr;
    } exp_t;

    typedef struct {
        logic              btn;
        logic              ready;
        logic              exp_mem_en;
        logic [ADDR_W-1:0] exp_pc;
        logic              exp_valid;
    } vec_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   n_checks;
    int   n_fail;
    int   hs_count;
    int   mem_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change and direct checks happen just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor at the falling edge: a valid&ready seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) mem_cnt++;
            if (instr_valid && instr_ready) begin
                hs_count++;
                check("sb_queue_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    sb_e = sb_q.pop_front();
                    check("sb_instr", instr_out, sb_e.instr);
                    check("sb_pc", 32'(pc_out), 32'(sb_e.pc));
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_instr", instr_out, 32'd0);
        sb_q.delete();
        hs_count = 0;
        mem_cnt  = 0;
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(instr_valid), 32'd1);
    endtask

    vec_t vecs[17];
    int   n;

    initial begin
        for (int i = 0; i < PROG_LEN; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h00A00513;
        mem[1] = 32'h00F00793;
        mem[2] = 32'h01F50C13;
        mem[6] = NOP;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; step_btn = 1'b0; run_mode = 1'b0; instr_ready = 1'b0;
        jump_en = 1'b0; jump_addr = '0;

        // Button held through reset in step mode must not start a fetch.
        step_btn = 1'b1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            check("held_btn_mem_en", 32'(mem_en), 32'd0);
            check("held_btn_pc", 32'(pc_out), 32'd0);
            check("held_btn_valid", 32'(instr_valid), 32'd0);
        end
        step_btn = 1'b0;
        step();
        step_btn = 1'b1;
        instr_ready = 1'b1;
        sb_q.push_back('{pc: 5'd0, instr: mem[0]});
        step();
        step_btn = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("repress_one_fetch", 32'(mem_cnt), 32'd1);
        check("repress_pc", 32'(pc_out), 32'd1);
        check("repress_sb_empty", 32'(sb_q.size()), 32'd0);

        // Step mode, per-cycle vectors: {btn, ready, exp mem_en, exp pc, exp valid}.
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 5'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 5'd1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 5'd1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 5'd1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 5'd2, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 5'd2, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 5'd2, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 5'd3, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 5'd3, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 5'd3, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 5'd3, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 5'd3, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 5'd3, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 5'd4, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 5'd4, 1'b0};
        step_btn = 1'b0; run_mode = 1'b0; instr_ready = 1'b1;
        do_reset();
        for (int p = 0; p < 4; p++) sb_q.push_back('{pc: 5'(p), instr: mem[p]});
        for (int i = 0; i < 17; i++) begin
            step_btn    = vecs[i].btn;
            instr_ready = vecs[i].ready;
            step();
            check($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].exp_mem_en));
            check($sformatf("vec%0d_pc", i), 32'(pc_out), 32'(vecs[i].exp_pc));
            check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_halted", i), 32'(halted), 32'd0);
            if (i == 11) check("step_mem_en_cycles", 32'(mem_cnt), 32'd3);
        end
        check("step_sb_empty", 32'(sb_q.size()), 32'd0);

        // Free run to the end of the program at one instruction per two cycles.
        run_mode = 1'b1; instr_ready = 1'b1; step_btn = 1'b0;
        do_reset();
        for (int p = 0; p <= RUN_LAST; p++) sb_q.push_back('{pc: 5'(p), instr: mem[p]});
        n = 0;
        while (!halted && n < 200) begin
            step();
            n++;
        end
        check("run_cycles_to_halt", 32'(n), 32'(3 + 2 * RUN_LAST));
        check("run_halted", 32'(halted), 32'd1);
        check("run_pc_final", 32'(pc_out), 32'(RUN_LAST));
        check("run_valid_final", 32'(instr_valid), 32'd0);
        check("run_handshakes", 32'(hs_count), 32'(RUN_LAST + 1));
        check("run_sb_empty", 32'(sb_q.size()), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step_btn = i[0];
            run_mode = i[1];
            step();
            check("halt_pc_holds", 32'(pc_out), 32'(RUN_LAST));
            check("halt_stays", 32'(halted), 32'd1);
            check("halt_mem_en", 32'(mem_en), 32'd0);
        end
        check("halt_no_fetch", 32'(mem_cnt), 32'(RUN_LAST + 1));

        // Backpressure in HOLD, then reset while an instruction is pending.
        run_mode = 1'b1; instr_ready = 1'b0; step_btn = 1'b0;
        do_reset();
        wait_valid("bp_first_valid");
        sb_q.push_back('{pc: 5'd0, instr: mem[0]});
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_instr", instr_out, mem[0]);
            check("bp_pc", 32'(pc_out), 32'd0);
            check("bp_mem_en", 32'(mem_en), 32'd0);
        end
        instr_ready = 1'b1;
        step();
        check("bp_release_pc", 32'(pc_out), 32'd1);
        check("bp_release_valid", 32'(instr_valid), 32'd0);
        check("bp_release_fetch", 32'(mem_en), 32'd1);
        instr_ready = 1'b0;
        wait_valid("bp_second_valid");
        check("bp_second_instr", instr_out, mem[1]);
        check("bp_sb_empty", 32'(sb_q.size()), 32'd0);
        do_reset();

        // Jumps: ignored in IDLE and without handshake, override halt at the last PC.
        run_mode = 1'b0; instr_ready = 1'b0; jump_en = 1'b1; jump_addr = 5'd9;
        do_reset();
        for (int i = 0; i < 3; i++) step();
        check("jump_idle_ignored", 32'(pc_out), 32'd0);
        run_mode = 1'b1;
        wait_valid("jump_first_valid");
        step();
        check("jump_no_hs_pc", 32'(pc_out), 32'd0);
        check("jump_no_hs_instr", instr_out, mem[0]);
        sb_q.push_back('{pc: 5'd0, instr: mem[0]});
        sb_q.push_back('{pc: 5'd31, instr: mem[31]});
        jump_addr = 5'd31; instr_ready = 1'b1;
        step();
        check("jump_to_31_pc", 32'(pc_out), 32'd31);
        check("jump_to_31_fetch", 32'(mem_en), 32'd1);
        instr_ready = 1'b0; jump_en = 1'b0;
        wait_valid("jump_31_valid");
        check("jump_31_instr", instr_out, mem[31]);
        jump_en = 1'b1; jump_addr = 5'd4; instr_ready = 1'b1;
        step();
        check("jump_last_no_halt", 32'(halted), 32'd0);
        check("jump_last_pc", 32'(pc_out), 32'd4);
        check("jump_last_fetch", 32'(mem_en), 32'd1);
        instr_ready = 1'b0; jump_en = 1'b0;
        wait_valid("jump_4_valid");
        check("jump_4_instr", instr_out, mem[4]);
        check("jump_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
